// File: rtl/logic_pipe_pkg.sv
// rtl/logic_pipe_pkg.sv - shared types and constants for the logic delay pipe
// Contents: op_e operation encoding, stage_t pipeline stage record, CNT_W.
// stage_t carries a MAX_WIDTH result field; users store WIDTH bits in the
// low end and leave the rest zero, so one type serves every WIDTH <= MAX_WIDTH.
package logic_pipe_pkg;

  localparam int CNT_W     = 16;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_CAT = 2'd3
  } op_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] res;
    logic                 flag;
  } stage_t;

endpackage

// File: rtl/logic_pipe_alu.sv
// rtl/logic_pipe_alu.sv - combinational operation and flag unit
// Ports:
//   op   in  operation select (op_e)
//   a, b in  WIDTH-bit operands
//   res  out operation result; CAT packs the low halves of a and b
//   flag out (|(a^b)) & (|(a&b))
import logic_pipe_pkg::*;

module logic_pipe_alu #(
  parameter int WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             flag
);

  localparam int HALF = WIDTH / 2;

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_CAT:  res = {a[HALF-1:0], b[HALF-1:0]};
      default: res = '0;
    endcase
  end

  assign flag = (|(a ^ b)) & (|(a & b));

endmodule

// File: rtl/logic_delay_pipe.sv
// rtl/logic_delay_pipe.sv - bitwise op unit with runtime-programmable cycle latency
// Optional feature macro: LOGIC_PIPE_CNT_EN (adds the saturating beat_cnt output).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cfg_wr, cfg_lat      latency write (accepted only when empty and 1..DEPTH)
//   cfg_err              one-cycle pulse after a rejected latency write
//   lat                  current latency
//   in_valid/in_ready    input handshake; in_op, in_a, in_b carry the beat
//   out_valid/out_ready  output handshake; out_res, out_flag carry the result
//   empty                no valid beat held in any stage
//   beat_cnt             output handshake count (LOGIC_PIPE_CNT_EN only)
import logic_pipe_pkg::*;

module logic_delay_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [LW-1:0]    cfg_lat,
  output logic             cfg_err,
  output logic [LW-1:0]    lat,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_flag,
  output logic             empty
`ifdef LOGIC_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  stage_t           stage_q [DEPTH];
  stage_t           stage_d [DEPTH];
  stage_t           new_stage;
  logic [LW-1:0]    lat_q, lat_d;
  logic             cfg_err_q, cfg_err_d;
  logic             stall;
  logic             accept;
  logic             cfg_ok;
  logic             any_valid;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;

  logic_pipe_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (op_e'(in_op)),
    .a    (in_a),
    .b    (in_b),
    .res  (alu_res),
    .flag (alu_flag)
  );

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  // The whole chain freezes while the head beat waits on downstream.
  assign stall    = stage_q[DEPTH-1].valid & ~out_ready;
  assign in_ready = ~stall & ~cfg_wr & ~rst;
  assign accept   = in_valid & in_ready;
  assign empty    = ~any_valid;
  assign cfg_ok   = cfg_wr & empty & (cfg_lat != '0) & (cfg_lat <= LW'(DEPTH));

  always_comb begin
    new_stage                = '0;
    new_stage.valid          = 1'b1;
    new_stage.res[WIDTH-1:0] = alu_res;
    new_stage.flag           = alu_flag;
  end

  // Beats enter at stage DEPTH-lat so they reach the head after lat-1 shifts.
  // With lat fixed, the stage below the entry point is always empty, so the
  // override never clobbers an in-flight beat.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (!stall) begin
      stage_d[0] = '0;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == DEPTH - int'(lat_q)) begin
          stage_d[i] = new_stage;
        end
      end
    end
  end

  always_comb begin
    lat_d     = cfg_ok ? cfg_lat : lat_q;
    cfg_err_d = cfg_wr & ~cfg_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      lat_q     <= LW'(DEPTH);
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      lat_q     <= lat_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_res   = stage_q[DEPTH-1].res[WIDTH-1:0];
  assign out_flag  = stage_q[DEPTH-1].flag;
  assign lat       = lat_q;
  assign cfg_err   = cfg_err_q;

`ifdef LOGIC_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of output handshakes.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_logic_delay_pipe.sv
// tb/tb_logic_delay_pipe.sv - directed self-checking bench for logic_delay_pipe
module tb_logic_delay_pipe;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_wr;
  logic [LW-1:0]    cfg_lat;
  logic             cfg_err;
  logic [LW-1:0]    lat;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_flag;
  logic             empty;
`ifdef LOGIC_PIPE_CNT_EN
  logic [15:0]      beat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_delay_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_lat   (cfg_lat),
    .cfg_err   (cfg_err),
    .lat       (lat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flag  (out_flag),
    .empty     (empty)
`ifdef LOGIC_PIPE_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_wr = 1'b0; cfg_lat = '0; in_valid = 1'b0; in_op = 2'd0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    step(); step(); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (lat !== 4'd8) begin n_fail++; $display("FAIL reset_lat: got %0d expected 8", lat); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    n_checks++; if (out_res !== 4'b0000) begin n_fail++; $display("FAIL reset_out_res: got %b expected 0000", out_res); end
    n_checks++; if (out_flag !== 1'b0) begin n_fail++; $display("FAIL reset_out_flag: got %b expected 0", out_flag); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
`ifdef LOGIC_PIPE_CNT_EN
    n_checks++; if (beat_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_beat_cnt: got %h expected 0000", beat_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_xor_max_lat();
    step();
    in_valid = 1'b1; in_op = 2'd2; in_a = 4'b1100; in_b = 4'b1010;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL xor_in_ready: got %b expected 1", in_ready); end
    for (int e = 0; e <= 8; e++) begin
      step();
      in_valid = 1'b0; in_a = 4'b0000; in_b = 4'b1111;
      n_checks++; if (out_valid !== (e == 7)) begin n_fail++; $display("FAIL xor_out_valid_e%0d: got %b expected %b", e, out_valid, (e == 7)); end
      if (e == 7) begin
        n_checks++; if (out_res !== 4'b0110) begin n_fail++; $display("FAIL xor_out_res: got %b expected 0110", out_res); end
        n_checks++; if (out_flag !== 1'b1) begin n_fail++; $display("FAIL xor_out_flag: got %b expected 1", out_flag); end
      end
      if (e == 0) begin
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL xor_empty_busy: got %b expected 0", empty); end
      end
      if (e == 8) begin
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL xor_empty_drained: got %b expected 1", empty); end
      end
    end
  endtask

  task automatic test_lat1_back_to_back();
    logic [1:0] t_op   [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [3:0] t_a    [4] = '{4'b1100, 4'b1100, 4'b1100, 4'b0101};
    logic [3:0] t_b    [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0101};
    logic [3:0] t_res  [4] = '{4'b1000, 4'b1110, 4'b0010, 4'b0000};
    logic       t_flag [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    cfg_wr = 1'b1; cfg_lat = 4'd1;
    step();
    cfg_wr = 1'b0;
    n_checks++; if (lat !== 4'd1) begin n_fail++; $display("FAIL lat1_cfg_lat: got %0d expected 1", lat); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL lat1_cfg_err: got %b expected 0", cfg_err); end
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_op = t_op[i]; in_a = t_a[i]; in_b = t_b[i];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat1_in_ready_%0d: got %b expected 1", i, in_ready); end
      end
      step();
      if (i < 4) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat1_out_valid_%0d: got %b expected 1", i, out_valid); end
        n_checks++; if (out_res !== t_res[i]) begin n_fail++; $display("FAIL lat1_out_res_%0d: got %b expected %b", i, out_res, t_res[i]); end
        n_checks++; if (out_flag !== t_flag[i]) begin n_fail++; $display("FAIL lat1_out_flag_%0d: got %b expected %b", i, out_flag, t_flag[i]); end
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat1_drained: got %b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0] t_op   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] t_a    [4] = '{4'b1111, 4'b0001, 4'b1001, 4'b0110};
    logic [3:0] t_b    [4] = '{4'b0011, 4'b0010, 4'b0110, 4'b1011};
    logic [3:0] t_res  [4] = '{4'b0011, 4'b0011, 4'b1111, 4'b1011};
    logic       t_flag [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k;
    int x;
    cfg_wr = 1'b1; cfg_lat = 4'd3;
    step();
    cfg_wr = 1'b0;
    n_checks++; if (lat !== 4'd3) begin n_fail++; $display("FAIL stall_cfg_lat: got %0d expected 3", lat); end
    for (int c = 0; c <= 12; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      if (c <= 8) begin
        k = (c < 3) ? c : 3;
        in_valid = 1'b1; in_op = t_op[k]; in_a = t_a[k]; in_b = t_b[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c <= 8) begin
        n_checks++; if (in_ready !== (c < 3 || c == 8)) begin n_fail++; $display("FAIL stall_in_ready_c%0d: got %b expected %b", c, in_ready, (c < 3 || c == 8)); end
      end
      x = (c >= 3 && c <= 8) ? 0 : (c == 9) ? 1 : (c == 10) ? 2 : (c == 11) ? 3 : -1;
      n_checks++; if (out_valid !== (x >= 0)) begin n_fail++; $display("FAIL stall_out_valid_c%0d: got %b expected %b", c, out_valid, (x >= 0)); end
      if (x >= 0) begin
        n_checks++; if (out_res !== t_res[x]) begin n_fail++; $display("FAIL stall_out_res_c%0d: got %b expected %b", c, out_res, t_res[x]); end
        n_checks++; if (out_flag !== t_flag[x]) begin n_fail++; $display("FAIL stall_out_flag_c%0d: got %b expected %b", c, out_flag, t_flag[x]); end
      end
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_cfg_reject();
    logic [3:0] bad [2] = '{4'd0, 4'd9};
    for (int i = 0; i < 2; i++) begin
      cfg_wr = 1'b1; cfg_lat = bad[i];
      in_valid = 1'b1; in_op = 2'd0; in_a = 4'b1111; in_b = 4'b1111;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rej%0d_in_ready: got %b expected 0", i, in_ready); end
      step();
      cfg_wr = 1'b0; in_valid = 1'b0;
      n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej%0d_cfg_err: got %b expected 1", i, cfg_err); end
      n_checks++; if (lat !== 4'd3) begin n_fail++; $display("FAIL rej%0d_lat: got %0d expected 3", i, lat); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rej%0d_no_beat: got empty=%b expected 1", i, empty); end
      step();
      n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rej%0d_cfg_err_pulse: got %b expected 0", i, cfg_err); end
    end
    in_valid = 1'b1; in_op = 2'd1; in_a = 4'b0100; in_b = 4'b0001;
    step();
    in_valid = 1'b0; cfg_wr = 1'b1; cfg_lat = 4'd5;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL busy_empty: got %b expected 0", empty); end
    step();
    cfg_wr = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL busy_cfg_err: got %b expected 1", cfg_err); end
    n_checks++; if (lat !== 4'd3) begin n_fail++; $display("FAIL busy_lat: got %0d expected 3", lat); end
    step();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL busy_cfg_err_pulse: got %b expected 0", cfg_err); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL busy_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_res !== 4'b0101) begin n_fail++; $display("FAIL busy_out_res: got %b expected 0101", out_res); end
    step();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL busy_drained: got %b expected 1", empty); end
    cfg_wr = 1'b1; cfg_lat = 4'd8;
    step();
    cfg_wr = 1'b0;
    n_checks++; if (lat !== 4'd8) begin n_fail++; $display("FAIL cfg_max_lat: got %0d expected 8", lat); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_max_err: got %b expected 0", cfg_err); end
  endtask

  task automatic test_reset_midflight();
    cfg_wr = 1'b1; cfg_lat = 4'd3;
    step();
    cfg_wr = 1'b0;
    n_checks++; if (lat !== 4'd3) begin n_fail++; $display("FAIL rstmid_cfg_lat: got %0d expected 3", lat); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'd2; in_a = 4'(i + 1); in_b = 4'b1000;
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_out_valid: got %b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready); end
    step();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 1", empty); end
    n_checks++; if (lat !== 4'd8) begin n_fail++; $display("FAIL rstmid_lat: got %0d expected 8", lat); end
    for (int e = 0; e < 10; e++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_e%0d: got %b expected 0", e, out_valid); end
    end
  endtask

`ifdef LOGIC_PIPE_CNT_EN
  task automatic test_beat_cnt();
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'd1; in_a = 4'b0011; in_b = 4'b0101;
    repeat (100) step();
    n_checks++; if (beat_cnt !== 16'd92) begin n_fail++; $display("FAIL cnt_partial: got %0d expected 92", beat_cnt); end
    repeat (70000) step();
    n_checks++; if (beat_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h expected ffff", beat_cnt); end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (beat_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_clear: got %h expected 0000", beat_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_xor_max_lat();
    test_lat1_back_to_back();
    test_stall();
    test_cfg_reject();
    test_reset_midflight();
`ifdef LOGIC_PIPE_CNT_EN
    test_beat_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
